// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter for I-fetch and D load/store
// D wins by default; a starvation counter forces an I grant after STARVE_MAX D grants.
module mem_port_arbiter #(
  parameter int XLEN       = 32,
  parameter int ADDR_SIZE  = 5,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_req,
  input  logic [ADDR_SIZE-1:0] i_addr,
  output logic                 i_ack,
  output logic [XLEN-1:0]      i_rdata,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [ADDR_SIZE-1:0] d_addr,
  input  logic [XLEN-1:0]      d_wdata,
  output logic                 d_ack,
  output logic [XLEN-1:0]      d_rdata,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [XLEN-1:0]      mem_wdata,
  input  logic [XLEN-1:0]      mem_rdata,
  output logic                 F_stall,
  output logic                 MEM_stall
);
  localparam int CW = $clog2(MEM_LAT + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [CW-1:0] LAT_LOAD   = CW'(MEM_LAT);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic [1:0]           state_q, state_d;
  logic                 own_d_q, own_d_d;
  logic                 we_q, we_d;
  logic                 mem_en_q, mem_en_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [XLEN-1:0]      wdata_q, wdata_d;
  logic [XLEN-1:0]      i_rdata_q, i_rdata_d;
  logic [XLEN-1:0]      d_rdata_q, d_rdata_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [SW-1:0]        starve_q, starve_d;
  logic                 gnt_dport, gnt_iport;

  always_comb begin
    gnt_dport = 1'b0;
    gnt_iport = 1'b0;
    if (state_q == IDLE) begin
      gnt_dport = d_req && !(i_req && starve_q == STARVE_LIM);
      gnt_iport = i_req && !gnt_dport;
    end
  end

  always_comb begin
    state_d   = state_q;
    own_d_d   = own_d_q;
    we_d      = we_q;
    mem_en_d  = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    cnt_d     = cnt_q;
    starve_d  = starve_q;
    case (state_q)
      IDLE: begin
        if (gnt_dport || gnt_iport) begin
          state_d  = BUSY;
          own_d_d  = gnt_dport;
          we_d     = gnt_dport && d_we;
          mem_en_d = 1'b1;
          cnt_d    = LAT_LOAD;
          addr_d   = gnt_dport ? d_addr : i_addr;
          if (gnt_dport) wdata_d = d_wdata;
          // Only D grants made while I is waiting count toward starvation
          if (gnt_iport || !i_req) starve_d = '0;
          else if (starve_q != STARVE_LIM) starve_d = starve_q + SW'(1);
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          if (!we_q) begin
            if (own_d_q) d_rdata_d = mem_rdata;
            else         i_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      own_d_q   <= 1'b0;
      we_q      <= 1'b0;
      mem_en_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      cnt_q     <= '0;
      starve_q  <= '0;
    end else begin
      state_q   <= state_d;
      own_d_q   <= own_d_d;
      we_q      <= we_d;
      mem_en_q  <= mem_en_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      cnt_q     <= cnt_d;
      starve_q  <= starve_d;
    end
  end

  assign i_ack     = (state_q == DONE) && !own_d_q;
  assign d_ack     = (state_q == DONE) && own_d_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_en_q && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign F_stall   = i_req && !i_ack;
  assign MEM_stall = d_req && !d_ack;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
// Directed timing scenarios plus randomized I/D traffic against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int MEM_LAT = 1;
  localparam int SM      = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        i_req, d_req, d_we;
  logic [4:0]  i_addr, d_addr;
  logic [31:0] d_wdata;
  logic        i_ack, d_ack, mem_en, mem_we, F_stall, MEM_stall;
  logic [31:0] i_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [4:0]  mem_addr;

  logic        i3_req;
  logic [4:0]  i3_addr;
  logic        i3_ack, d3_ack, m3_en, m3_we, f3_stall, ms3_stall;
  logic [31:0] i3_rdata, d3_rdata, m3_wdata, m3_rdata;
  logic [4:0]  m3_addr;

  mem_port_arbiter #(.XLEN(32), .ADDR_SIZE(5), .MEM_LAT(MEM_LAT), .STARVE_MAX(SM)) u_dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .F_stall(F_stall), .MEM_stall(MEM_stall)
  );

  mem_port_arbiter #(.XLEN(32), .ADDR_SIZE(5), .MEM_LAT(3), .STARVE_MAX(SM)) u_dut3 (
    .clk(clk), .rst(rst),
    .i_req(i3_req), .i_addr(i3_addr), .i_ack(i3_ack), .i_rdata(i3_rdata),
    .d_req(1'b0), .d_we(1'b0), .d_addr(5'd0), .d_wdata(32'd0),
    .d_ack(d3_ack), .d_rdata(d3_rdata),
    .mem_en(m3_en), .mem_we(m3_we), .mem_addr(m3_addr), .mem_wdata(m3_wdata),
    .mem_rdata(m3_rdata), .F_stall(f3_stall), .MEM_stall(ms3_stall)
  );

  // Memory: untouched words come from seed(); read data is junk except MEM_LAT cycles after a read
  bit   [31:0] wr_mask;
  logic [31:0] wr_data [32];
  logic [31:0] rd_pipe;
  logic [31:0] rd3_pipe [3];

  function automatic logic [31:0] seed(input int a);
    return (a == 3) ? 32'hDEADBEEF : (32'hC0DE_0000 | 32'(a * 97 + 11));
  endfunction

  function automatic logic [31:0] mem_rd(input logic [4:0] a);
    return wr_mask[a] ? wr_data[a] : seed(int'(a));
  endfunction

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      wr_mask[mem_addr] <= 1'b1;
      wr_data[mem_addr] <= mem_wdata;
    end
    rd_pipe     <= (mem_en && !mem_we) ? mem_rd(mem_addr) : $urandom;
    rd3_pipe[0] <= m3_en ? mem_rd(m3_addr) : $urandom;
    rd3_pipe[1] <= rd3_pipe[0];
    rd3_pipe[2] <= rd3_pipe[1];
  end
  assign mem_rdata = rd_pipe;
  assign m3_rdata  = rd3_pipe[2];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] mdl_mem [32];
  logic [31:0] last_dload;
  logic [31:0] exp_i [$];
  logic [31:0] exp_d [$];
  int          en_q [$];
  bit          owner_log [$];
  int          last_iack_cyc, last_dack_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: scoreboard pops, access-shape checks and arbitration rule per completed grant
  initial begin : monitor
    bit prev_en, prev_i, prev_d, acc_i, acc_d, pend;
    int en_cyc, scnt;
    prev_en = 0; prev_i = 0; prev_d = 0; acc_i = 0; acc_d = 0; pend = 0; en_cyc = 0; scnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_en = 0; prev_i = 0; prev_d = 0; pend = 0; scnt = 0;
      end else begin
        if (mem_en) begin
          chk("mem_en_back_to_back", 32'(prev_en), 0);
          chk("mem_en_while_outstanding", 32'(pend), 0);
          en_q.push_back(cyc);
          en_cyc = cyc; acc_i = prev_i; acc_d = prev_d; pend = 1;
        end
        if (mem_we) chk("mem_we_without_en", 32'(mem_en), 1);
        if (i_ack || d_ack) begin
          chk("ack_without_access", 32'(pend), 1);
          chk("ack_latency", cyc - en_cyc, MEM_LAT + 1);
          chk("dual_ack", 32'(i_ack && d_ack), 0);
          pend = 0;
        end
        if (d_ack) begin
          last_dack_cyc = cyc;
          owner_log.push_back(1'b0);
          chk("grant_rule_d", 32'(acc_d && !(acc_i && scnt == SM)), 1);
          scnt = acc_i ? ((scnt < SM) ? scnt + 1 : SM) : 0;
          chk("d_sb_has_entry", 32'(exp_d.size() > 0), 1);
          if (exp_d.size() > 0) chk("d_rdata", d_rdata, exp_d.pop_front());
        end
        if (i_ack) begin
          last_iack_cyc = cyc;
          owner_log.push_back(1'b1);
          chk("grant_rule_i", 32'(acc_i && (!acc_d || scnt == SM)), 1);
          scnt = 0;
          chk("i_sb_has_entry", 32'(exp_i.size() > 0), 1);
          if (exp_i.size() > 0) chk("i_rdata", i_rdata, exp_i.pop_front());
        end
        prev_en = mem_en; prev_i = i_req; prev_d = d_req;
      end
    end
  end

  task automatic wait_ack(input bit port_d, input string nm);
    bit got = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk); #1;
      if (port_d ? d_ack : i_ack) begin got = 1; break; end
    end
    chk(nm, 32'(got), 1);
  endtask

  task automatic do_i(input logic [4:0] a);
    @(posedge clk); #1;
    i_addr = a; i_req = 1'b1;
    exp_i.push_back(mdl_mem[a]);
    wait_ack(1'b0, "i_ack_timeout");
    @(posedge clk); #1;
    i_req = 1'b0;
  endtask

  task automatic do_d(input logic we, input logic [4:0] a, input logic [31:0] wd);
    @(posedge clk); #1;
    d_we = we; d_addr = a; d_wdata = wd; d_req = 1'b1;
    if (we) mdl_mem[a] = wd;
    else    last_dload = mdl_mem[a];
    exp_d.push_back(last_dload);
    wait_ack(1'b1, "d_ack_timeout");
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  task automatic step_drop();
    bit ia, da;
    @(negedge clk); #1;
    ia = i_ack; da = d_ack;
    @(posedge clk); #1;
    if (ia) i_req = 1'b0;
    if (da) d_req = 1'b0;
  endtask

  task automatic test1();
    int t0;
    @(posedge clk); #1;
    en_q.delete(); last_iack_cyc = -100; t0 = cyc;
    i_addr = 5'd3; i_req = 1'b1;
    exp_i.push_back(mdl_mem[3]);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      chk("t1_f_stall", 32'(F_stall), 32'(k < 3));
    end
    chk("t1_iack_cycle", last_iack_cyc - t0, 3);
    chk("t1_en_count", en_q.size(), 1);
    chk("t1_en_cycle", (en_q.size() > 0) ? en_q[0] - t0 : -1, 1);
    chk("t1_rdata", i_rdata, 32'hDEADBEEF);
    @(posedge clk); #1;
    i_req = 1'b0;
  endtask

  initial begin : stim
    int t0, pat;
    i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    i3_req = 0; i3_addr = 0;
    for (int a = 0; a < 32; a++) mdl_mem[a] = seed(a);
    last_dload = 0; last_iack_cyc = -100; last_dack_cyc = -100;

    repeat (2) @(posedge clk); #1;
    chk("reset_strobes", 32'({mem_en, mem_we, i_ack, d_ack, F_stall, MEM_stall}), 0);
    chk("reset_mem_addr", 32'(mem_addr), 0);
    chk("reset_rdata", i_rdata | d_rdata | mem_wdata, 0);
    rst = 1'b0;

    test1();

    // I and D together: D first, I accepted at the end of cycle 4
    @(posedge clk); #1;
    en_q.delete(); last_iack_cyc = -100; last_dack_cyc = -100; t0 = cyc;
    i_addr = 5'd1; i_req = 1'b1; d_addr = 5'd5; d_we = 1'b0; d_req = 1'b1;
    exp_i.push_back(mdl_mem[1]); exp_d.push_back(mdl_mem[5]); last_dload = mdl_mem[5];
    repeat (9) step_drop();
    chk("t2_dack_cycle", last_dack_cyc - t0, 3);
    chk("t2_iack_cycle", last_iack_cyc - t0, 7);
    chk("t2_en_count", en_q.size(), 2);
    chk("t2_en0", (en_q.size() > 0) ? en_q[0] - t0 : -1, 1);
    chk("t2_en1", (en_q.size() > 1) ? en_q[1] - t0 : -1, 5);

    // Store, then load back the same word
    @(posedge clk); #1;
    last_dack_cyc = -100; t0 = cyc;
    d_addr = 5'd7; d_we = 1'b1; d_wdata = 32'h12345678; d_req = 1'b1;
    mdl_mem[7] = 32'h12345678; exp_d.push_back(last_dload);
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("t3_mem_en_we", 32'({mem_en, mem_we}), 3);
    chk("t3_mem_addr", 32'(mem_addr), 7);
    chk("t3_mem_wdata", mem_wdata, 32'h12345678);
    repeat (4) step_drop();
    chk("t3_dack_cycle", last_dack_cyc - t0, 3);
    do_d(1'b0, 5'd7, 32'd0);
    chk("t3_load_back", d_rdata, 32'h12345678);

    // Both held: grant order D,D,I,D,D,I
    @(posedge clk); #1;
    en_q.delete(); owner_log.delete();
    i_addr = 5'd2; d_addr = 5'd20; d_we = 1'b0; i_req = 1'b1; d_req = 1'b1;
    repeat (2) exp_i.push_back(mdl_mem[2]);
    repeat (4) exp_d.push_back(mdl_mem[20]);
    last_dload = mdl_mem[20];
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (en_q.size() >= 6) break;
    end
    chk("t4_grants_issued", en_q.size(), 6);
    @(posedge clk); #1;
    i_req = 1'b0; d_req = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    pat = 0;
    foreach (owner_log[k]) if (k < 6 && owner_log[k]) pat |= (1 << k);
    chk("t4_grant_count", owner_log.size(), 6);
    chk("t4_grant_order", pat, 32'b100100);

    // Reset in the middle of a D load: everything clears at once, no ack follows
    @(posedge clk); #1;
    d_addr = 5'd9; d_we = 1'b0; d_req = 1'b1;
    @(posedge clk); #2;
    chk("t5_busy_en", 32'(mem_en), 1);
    rst = 1'b1;
    #1;
    chk("t5_strobes", 32'({mem_en, mem_we, i_ack, d_ack}), 0);
    chk("t5_mem_addr", 32'(mem_addr), 0);
    chk("t5_rdata", i_rdata | d_rdata, 0);
    d_req = 1'b0;
    exp_i.delete(); exp_d.delete(); last_dload = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    test1();

    // MEM_LAT=3 instance: ack five cycles after the request
    begin : t6
      int en_at, ack_at, n_en;
      logic [31:0] dat;
      en_at = -1; ack_at = -1; n_en = 0; dat = 0;
      @(posedge clk); #1;
      i3_addr = 5'd3; i3_req = 1'b1;
      for (int k = 0; k < 9; k++) begin
        @(negedge clk); #1;
        if (m3_en) begin n_en++; if (en_at < 0) en_at = k; end
        if (i3_ack) begin ack_at = k; dat = i3_rdata; end
        @(posedge clk); #1;
        if (ack_at == k) i3_req = 1'b0;
      end
      chk("t6_en_cycle", en_at, 1);
      chk("t6_en_count", n_en, 1);
      chk("t6_ack_cycle", ack_at, 5);
      chk("t6_rdata", dat, mdl_mem[3]);
    end

    // Random traffic: I reads words 0-15, D loads/stores words 16-31
    fork
      begin
        repeat (25) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          do_i(5'($urandom_range(0, 15)));
        end
      end
      begin
        repeat (40) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          do_d(1'($urandom_range(0, 1)), 5'(16 + $urandom_range(0, 15)), $urandom);
        end
      end
    join

    repeat (6) @(posedge clk);
    #1;
    chk("i_sb_leftover", exp_i.size(), 0);
    chk("d_sb_leftover", exp_d.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: run exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
